// File: rtl/fum_mips_mc.sv
// -----------------------------------------------------------------------------
// fum_mips_mc
//   Multi-cycle FUM-MIPS core with a 16-bit instruction format and a
//   configurable datapath width. Instructions and data share one memory port
//   that uses a request/ready handshake, so the memory may stretch any access
//   by inserting wait states. A control FSM steps each instruction through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB). HALT is a terminal state that
//   only reset can leave.
//
// Parameters
//   DATA_W    register / ALU / data width (>= 16)
//   ADDR_W    byte address width (>= 13)
//   RESET_PC  PC value loaded on reset (even)
//
// Ports
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   mem_req    memory access request (FETCH and MEM states only)
//   mem_we     1 = store (sw), 0 = read
//   mem_addr   byte address of the access
//   mem_wdata  store data
//   mem_rdata  read data; instruction fetch uses bits [15:0]
//   mem_ready  the access completes in any cycle with mem_req && mem_ready
//   retire     one-cycle pulse in the final cycle of each instruction
//   halted     high once a HALT instruction has executed
// -----------------------------------------------------------------------------
module fum_mips_mc #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              retire,
   output logic              halted
);

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   localparam logic [3:0] OP_R    = 4'd0;
   localparam logic [3:0] OP_ADDI = 4'd1;
   localparam logic [3:0] OP_LW   = 4'd2;
   localparam logic [3:0] OP_SW   = 4'd3;
   localparam logic [3:0] OP_BEQ  = 4'd4;
   localparam logic [3:0] OP_BNE  = 4'd5;
   localparam logic [3:0] OP_J    = 4'd6;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

   state_t state;
   state_t next_state;

   // Low during the first cycle after reset release, so the reset state
   // (FETCH) never requests memory while rst_n is still asserted.
   logic run;

   logic [ADDR_W-1:0] pc;
   logic [15:0]       ir;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] mdr;
   logic [DATA_W-1:0] rf [8];

   // Instruction fields
   logic [3:0] op;
   logic [2:0] rs;
   logic [2:0] rt;
   logic [2:0] rd;
   logic [2:0] funct;

   assign op    = ir[15:12];
   assign rs    = ir[11:9];
   assign rt    = ir[8:6];
   assign rd    = ir[5:3];
   assign funct = ir[2:0];

   logic [DATA_W-1:0] imm_sext;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] jump_target;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] alu_result;
   logic              take_branch;
   logic              fire;
   logic [2:0]        wb_idx;
   logic [DATA_W-1:0] wb_data;

   assign imm_sext = {{(DATA_W-6){ir[5]}}, ir[5:0]};
   // Branch offset counts halfwords; pc already holds pc+2 when EXEC runs.
   assign br_off   = {{(ADDR_W-7){ir[5]}}, ir[5:0], 1'b0};

   assign take_branch = ((op == OP_BEQ) && (a == b)) ||
                        ((op == OP_BNE) && (a != b));

   assign fire    = mem_req & mem_ready;
   assign wb_idx  = (op == OP_R)  ? rd  : rt;
   assign wb_data = (op == OP_LW) ? mdr : alu_out;

   generate
      if (ADDR_W <= DATA_W) begin : g_addr_trunc
         assign data_addr = alu_out[ADDR_W-1:0];
      end else begin : g_addr_ext
         assign data_addr = {{(ADDR_W-DATA_W){1'b0}}, alu_out};
      end

      // Jumps keep the region bits above bit 12 of the incremented pc.
      if (ADDR_W > 13) begin : g_jmp_region
         assign jump_target = {pc[ADDR_W-1:13], ir[11:0], 1'b0};
      end else begin : g_jmp_flat
         assign jump_target = {ir[11:0], 1'b0};
      end
   endgenerate

   // ALU: R-type decodes funct; addi/lw/sw add the sign-extended immediate.
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      alu_result = a + imm_sext;
      if (op == OP_R) begin
         case (funct)
            3'd0:    alu_result = a + b;
            3'd1:    alu_result = a - b;
            3'd2:    alu_result = a & b;
            3'd3:    alu_result = a | b;
            3'd4:    alu_result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_result = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   // NOTE: clocked state is assigned with non-blocking assignments so every
   // register samples the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      next_state = state;
      case (state)
         FETCH:  if (fire) next_state = DECODE;
         DECODE: next_state = EXEC;
         EXEC: begin
            case (op)
               OP_R, OP_ADDI: next_state = WB;
               OP_LW, OP_SW:  next_state = MEM;
               OP_HALT:       next_state = HALT;
               default:       next_state = FETCH;
            endcase
         end
         MEM:    if (fire) next_state = (op == OP_SW) ? FETCH : WB;
         WB:     next_state = FETCH;
         HALT:   next_state = HALT;
         default: next_state = FETCH;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   // Address and store data come from pc / alu_out / b, none of which change
   // while an access is waiting, so they stay stable until mem_ready.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc;
      mem_wdata = b;
      retire    = 1'b0;
      halted    = 1'b0;
      case (state)
         FETCH: mem_req = run;
         EXEC: begin
            case (op)
               OP_R, OP_ADDI, OP_LW, OP_SW: retire = 1'b0;
               default:                     retire = 1'b1;
            endcase
         end
         MEM: begin
            mem_req  = 1'b1;
            mem_addr = data_addr;
            mem_we   = (op == OP_SW);
            retire   = mem_ready && (op == OP_SW);
         end
         WB:      retire = 1'b1;
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   // NOTE: the register file is only eight words and must read as zero
   // straight out of reset, so it sits in the reset branch with the rest of
   // the datapath rather than being left as an uninitialised memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run     <= 1'b0;
         pc      <= RESET_PC_V;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         for (int i = 0; i < 8; i++) begin
            rf[i] <= '0;
         end
      end else begin
         run <= 1'b1;
         case (state)
            FETCH: begin
               if (fire) begin
                  ir <= mem_rdata[15:0];
                  pc <= pc + ADDR_W'(2);
               end
            end
            DECODE: begin
               a <= rf[rs];
               b <= rf[rt];
            end
            EXEC: begin
               alu_out <= alu_result;
               if (take_branch) begin
                  pc <= pc + br_off;
               end else if (op == OP_J) begin
                  pc <= jump_target;
               end
            end
            MEM: begin
               if (fire && (op == OP_LW)) begin
                  mdr <= mem_rdata;
               end
            end
            WB: begin
               // r0 is never written, so it keeps reading zero.
               if (wb_idx != 3'd0) begin
                  rf[wb_idx] <= wb_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fum_mips_mc.md
# fum_mips_mc

Parametrised multi-cycle successor to the single-cycle FUM-MIPS core. It executes the same 16-bit instruction format with a configurable datapath width. One shared instruction/data memory port uses a request/ready handshake, so memory may insert any number of wait states. A control FSM sequences fetch, decode, execute, memory and writeback; the block adds asynchronous reset, a halt state and a retire strobe for the verification scoreboard.

## Interface
- DATA_W, 16: register/ALU/data width; must be ≥ 16.
- ADDR_W, 16: byte address width; must be ≥ 13.
- RESET_PC, 0: PC value loaded on reset; must be even.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (sw), 0 = read.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data; instruction fetch uses bits [15:0].
- mem_ready  in  1  access completes in any cycle where mem_req && mem_ready; may be tied high for zero-wait memory.
- retire  out  1  one-cycle pulse as each instruction completes.
- halted  out  1  high once a HALT instruction has executed.

## Operation
- Encoding: op=[15:12], rs=[11:9], rt=[8:6], rd=[5:3], funct=[2:0], imm6=[5:0], imm12=[11:0].
- Opcodes:
  - 0 R-type: funct 0 add, 1 sub, 2 and, 3 or, 4 slt (signed compare, result 1/0); other funct values write 0.
  - 1 addi: rt = rs + sext(imm6).
  - 2 lw: rt = M[rs + sext(imm6)].
  - 3 sw: M[rs + sext(imm6)] = rt.
  - 4 beq, 5 bne: if taken, pc = pc+2 + (sext(imm6)<<1).
  - 6 j: pc = {pc_plus2[ADDR_W-1:13], imm12, 1'b0}.
  - 15 halt.
  - Any other opcode: no-op, still retires.
- Register file: 8 × DATA_W. r0 reads 0; writes to r0 are dropped.
- Arithmetic: two's complement, wraps modulo 2^DATA_W. sext extends imm6 to DATA_W. Memory address = ALU result truncated to ADDR_W.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready: IR ← rdata[15:0], pc ← pc+2 (mod 2^ADDR_W), go to DECODE.
  - DECODE: A ← R[rs], B ← R[rt], go to EXEC.
  - EXEC:
    - R-type/addi: ALUOut ← result, go to WB.
    - lw/sw: ALUOut ← address, go to MEM.
    - beq/bne/j: update pc, retire, go to FETCH.
    - no-op: retire, go to FETCH.
    - halt: retire, go to HALT.
  - MEM: mem_req=1, mem_addr=ALUOut, mem_we=(op==sw), mem_wdata=B. On ready: sw retires and goes to FETCH; lw latches MDR and goes to WB.
  - WB: write R[rd] (R-type), R[rt] (addi), or R[rt]=MDR (lw). Retire, go to FETCH.
  - HALT: absorbing; leaves only via reset. mem_req=0, halted=1.
- mem_addr, mem_we and mem_wdata are held stable while mem_req is high and ready is low.

## Timing
- Reset values, asserted asynchronously: state=FETCH, pc=RESET_PC, all registers 0, IR 0, mem_req=0, mem_we=0, retire=0, halted=0.
- The first rising edge after rst_n deasserts enters FETCH with mem_req=1.
- mem_req is a registered/decoded function of state only. It must be 0 while rst_n=0, including when reset hits mid-access; the pending access is abandoned and never retired.
- Cycles with zero-wait memory: R/addi 4, lw 5, sw 4, beq/bne/j/no-op/halt 3. Each wait cycle on the active access adds 1.
- retire is asserted in the final cycle of an instruction (combinational on the state/ready condition) and is never high two cycles in a row.
- Branch and jump use the pc value already incremented in FETCH (pc+2). PC wrap from 0xFFFE goes to 0x0000 (ADDR_W=16).

## Test plan
- Reset: assert rst_n=0 mid-MEM with mem_req high -> mem_req drops immediately; after release, first fetch is at RESET_PC=0 and registers read 0.
- ALU sequence with mem_ready tied 1: addi r1,r0,-1 ; addi r2,r0,5 ; add r3,r1,r2 ; slt r4,r1,r2 -> r3=4, r4=1; retire pulses every 4 cycles.
- Wait states: random 0–3 cycle mem_ready delays; sw r2,2(r0) then lw r5,2(r0) -> write seen at addr 2 with data 5, r5=5, address/data held stable across waits.
- Branches: beq r0,r0,-1 loop -> pc revisits same address; bne r2,r2,+3 not taken -> next fetch at pc+2; j 0x010 -> next fetch 0x0020.
- Width generalisation at DATA_W=32: addi r1,r0,-1 -> r1=0xFFFFFFFF; add r1,r1,r1 -> 0xFFFFFFFE.
- Halt/edge cases: write to r0 leaves r0=0; pc at 0xFFFE fetches next at 0x0000; halt -> halted=1, mem_req stays 0 for 100 cycles.
